// File: rtl/fc_wr_burst_ctrl.sv
// Write-back engine for the fully-connected layer: captures one result vector
// and drains it to the memory bus as AW/W bursts of at most MAX_BURST beats.
module fc_wr_burst_ctrl #(
  parameter int         BATCH        = 2,
  parameter int         BIAS         = 10,
  parameter int         MAX_BURST    = 16,
  parameter logic [3:0] AWID         = 4'b0110,
  parameter bit         AP_LAST_ONLY = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      FcNwc_result_en,
  input  logic [BATCH*BIAS*32-1:0]  FcNwc_result,
  input  logic [27:0]               NcNwc_initAddr,
  input  logic                      NcNwc_initAddrEn,
  output logic                      NwcNc_busy,
  output logic                      NwcNc_done,
  output logic                      NwcNc_drop,
  input  logic                      BusNwc_awready,
  output logic                      NwcBus_awvalid,
  output logic [27:0]               NwcBus_awaddr,
  output logic [3:0]                NwcBus_awlen,
  output logic [3:0]                NwcBus_awuser_id,
  output logic                      NwcBus_awuser_ap,
  input  logic                      BusNwc_wready,
  output logic                      NwcBus_wvalid,
  output logic [31:0]               NwcBus_wdata,
  output logic [3:0]                NwcBus_wstrb,
  output logic                      NwcBus_wlast
);

  localparam int N  = BATCH * BIAS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [N*32-1:0]   data_r;
  logic [27:0]       base_r;
  logic [27:0]       job_base_r;
  logic [CW-1:0]     sent_r;
  logic [CW-1:0]     burst_end_r;
  logic [CW-1:0]     sent_n_s;

  // Beats in the burst that starts at word s: full bursts, remainder last.
  function automatic int beats_of(input int s);
    int rem;
    rem = N - s;
    return (rem > MAX_BURST) ? MAX_BURST : rem;
  endfunction

  function automatic logic ap_of(input int s);
    return AP_LAST_ONLY ? ((s + beats_of(s)) == N) : 1'b1;
  endfunction

  function automatic logic [31:0] word_at(input logic [CW-1:0] idx);
    return data_r[32*int'(idx) +: 32];
  endfunction

  assign sent_n_s = sent_r + CW'(1);

  // Job FSM; every bus and handshake output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      data_r           <= '0;
      base_r           <= 28'd0;
      job_base_r       <= 28'd0;
      sent_r           <= '0;
      burst_end_r      <= '0;
      NwcNc_busy       <= 1'b0;
      NwcNc_done       <= 1'b0;
      NwcNc_drop       <= 1'b0;
      NwcBus_awvalid   <= 1'b0;
      NwcBus_awaddr    <= 28'd0;
      NwcBus_awlen     <= 4'd0;
      NwcBus_awuser_id <= 4'd0;
      NwcBus_awuser_ap <= 1'b0;
      NwcBus_wvalid    <= 1'b0;
      NwcBus_wdata     <= 32'd0;
      NwcBus_wstrb     <= 4'd0;
      NwcBus_wlast     <= 1'b0;
    end else begin
      NwcNc_done <= 1'b0;
      NwcNc_drop <= FcNwc_result_en && (state_r != IDLE);
      if (NcNwc_initAddrEn) begin
        base_r <= NcNwc_initAddr;
      end
      case (state_r)
        IDLE: begin
          if (FcNwc_result_en) begin
            data_r           <= FcNwc_result;
            job_base_r       <= base_r;
            sent_r           <= '0;
            burst_end_r      <= CW'(beats_of(0));
            NwcNc_busy       <= 1'b1;
            NwcBus_awvalid   <= 1'b1;
            NwcBus_awaddr    <= base_r;
            NwcBus_awlen     <= 4'(beats_of(0) - 1);
            NwcBus_awuser_id <= AWID;
            NwcBus_awuser_ap <= ap_of(0);
            state_r          <= ADDR;
          end
        end
        ADDR: begin
          if (BusNwc_awready) begin
            NwcBus_awvalid <= 1'b0;
            NwcBus_wvalid  <= 1'b1;
            NwcBus_wstrb   <= 4'hF;
            NwcBus_wdata   <= word_at(sent_r);
            NwcBus_wlast   <= (sent_n_s == burst_end_r);
            state_r        <= DATA;
          end
        end
        DATA: begin
          if (BusNwc_wready) begin
            sent_r <= sent_n_s;
            if (NwcBus_wlast) begin
              NwcBus_wvalid <= 1'b0;
              NwcBus_wstrb  <= 4'd0;
              NwcBus_wlast  <= 1'b0;
              if (sent_n_s == CW'(N)) begin
                NwcNc_done <= 1'b1;
                NwcNc_busy <= 1'b0;
                state_r    <= DONE;
              end else begin
                // Address arithmetic wraps modulo 2^28.
                NwcBus_awvalid   <= 1'b1;
                NwcBus_awaddr    <= job_base_r + 28'({sent_n_s, 2'b00});
                NwcBus_awlen     <= 4'(beats_of(int'(sent_n_s)) - 1);
                NwcBus_awuser_ap <= ap_of(int'(sent_n_s));
                burst_end_r      <= CW'(int'(sent_n_s) + beats_of(int'(sent_n_s)));
                state_r          <= ADDR;
              end
            end else begin
              NwcBus_wdata <= word_at(sent_n_s);
              NwcBus_wlast <= ((sent_n_s + CW'(1)) == burst_end_r);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_wr_burst_ctrl.sv
// Directed bench for fc_wr_burst_ctrl: a job table for the default build plus
// hand sequences for drop, address wrap on a small build, and mid-job reset.
module tb_fc_wr_burst_ctrl;
  localparam int NW = 20;
  localparam int NS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             result_en, init_addr_en, busy, done, drop;
  logic [NW*32-1:0] result;
  logic [27:0]      init_addr, awaddr;
  logic             awready, awvalid, awuser_ap, wready, wvalid, wlast;
  logic [3:0]       awlen, awuser_id, wstrb;
  logic [31:0]      wdata;

  logic             s_result_en, s_init_addr_en, s_busy, s_done, s_drop;
  logic [NS*32-1:0] s_result;
  logic [27:0]      s_init_addr, s_awaddr;
  logic             s_awready, s_awvalid, s_awuser_ap, s_wready, s_wvalid, s_wlast;
  logic [3:0]       s_awlen, s_awuser_id, s_wstrb;
  logic [31:0]      s_wdata;

  fc_wr_burst_ctrl u_dut (
    .clk(clk), .rst(rst),
    .FcNwc_result_en(result_en), .FcNwc_result(result),
    .NcNwc_initAddr(init_addr), .NcNwc_initAddrEn(init_addr_en),
    .NwcNc_busy(busy), .NwcNc_done(done), .NwcNc_drop(drop),
    .BusNwc_awready(awready), .NwcBus_awvalid(awvalid), .NwcBus_awaddr(awaddr),
    .NwcBus_awlen(awlen), .NwcBus_awuser_id(awuser_id), .NwcBus_awuser_ap(awuser_ap),
    .BusNwc_wready(wready), .NwcBus_wvalid(wvalid), .NwcBus_wdata(wdata),
    .NwcBus_wstrb(wstrb), .NwcBus_wlast(wlast)
  );

  fc_wr_burst_ctrl #(.BATCH(1), .BIAS(8), .MAX_BURST(4)) u_small (
    .clk(clk), .rst(rst),
    .FcNwc_result_en(s_result_en), .FcNwc_result(s_result),
    .NcNwc_initAddr(s_init_addr), .NcNwc_initAddrEn(s_init_addr_en),
    .NwcNc_busy(s_busy), .NwcNc_done(s_done), .NwcNc_drop(s_drop),
    .BusNwc_awready(s_awready), .NwcBus_awvalid(s_awvalid), .NwcBus_awaddr(s_awaddr),
    .NwcBus_awlen(s_awlen), .NwcBus_awuser_id(s_awuser_id), .NwcBus_awuser_ap(s_awuser_ap),
    .BusNwc_wready(s_wready), .NwcBus_wvalid(s_wvalid), .NwcBus_wdata(s_wdata),
    .NwcBus_wstrb(s_wstrb), .NwcBus_wlast(s_wlast)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NW*32-1:0] make_words(input logic [31:0] seed);
    logic [NW*32-1:0] w;
    for (int k = 0; k < NW; k++) w[32*k +: 32] = seed + 32'(k);
    return w;
  endfunction

  // Bus monitor for the default build: logs handshakes, checks stall stability.
  logic [27:0] aw_addr_q[$];
  logic [3:0]  aw_len_q[$];
  logic        aw_ap_q[$];
  logic [31:0] beat_q[$];
  logic        last_q[$];
  int          done_cnt = 0;
  int          drop_cnt = 0;
  logic        aw_stall_p = 1'b0, w_stall_p = 1'b0, wlast_p = 1'b0;
  logic [27:0] aw_addr_p = 28'd0;
  logic [3:0]  aw_len_p = 4'd0;
  logic [31:0] wdata_p = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      aw_stall_p <= 1'b0;
      w_stall_p  <= 1'b0;
    end else begin
      if (awvalid) chk("aw_w_overlap", 32'(wvalid), 32'd0);
      chk("wstrb", 32'(wstrb), wvalid ? 32'hF : 32'h0);
      if (aw_stall_p) begin
        chk("awvalid_hold", 32'(awvalid), 32'd1);
        chk("awaddr_stable", 32'(awaddr), 32'(aw_addr_p));
        chk("awlen_stable", 32'(awlen), 32'(aw_len_p));
      end
      if (w_stall_p) begin
        chk("wvalid_hold", 32'(wvalid), 32'd1);
        chk("wdata_stable", wdata, wdata_p);
        chk("wlast_stable", 32'(wlast), 32'(wlast_p));
      end
      aw_stall_p <= awvalid && !awready;
      aw_addr_p  <= awaddr;
      aw_len_p   <= awlen;
      w_stall_p  <= wvalid && !wready;
      wdata_p    <= wdata;
      wlast_p    <= wlast;
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
        aw_ap_q.push_back(awuser_ap);
      end
      if (wvalid && wready) begin
        beat_q.push_back(wdata);
        last_q.push_back(wlast);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (drop) drop_cnt <= drop_cnt + 1;
    end
  end

  // Handshake log for the small build.
  logic [27:0] s_aw_addr_q[$];
  logic [3:0]  s_aw_len_q[$];
  logic        s_aw_ap_q[$];
  logic [31:0] s_beat_q[$];
  logic        s_last_q[$];
  int          s_done_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (s_awvalid && s_awready) begin
        s_aw_addr_q.push_back(s_awaddr);
        s_aw_len_q.push_back(s_awlen);
        s_aw_ap_q.push_back(s_awuser_ap);
      end
      if (s_wvalid && s_wready) begin
        s_beat_q.push_back(s_wdata);
        s_last_q.push_back(s_wlast);
      end
      if (s_done) s_done_cnt <= s_done_cnt + 1;
    end
  end

  typedef struct {
    bit          load;
    logic [27:0] base;
    int          aw_stall;
    bit          w_toggle;
    bit          mid_load;
    logic [27:0] mid_addr;
    bit          mid_strobe;
    logic [27:0] exp_a0;
    logic [27:0] exp_a1;
    logic [3:0]  exp_len0;
    logic [3:0]  exp_len1;
  } vec_t;

  vec_t vecs[6];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
    chk({tag, "_wlast"}, 32'(wlast), 32'd0);
    chk({tag, "_awaddr"}, 32'(awaddr), 32'd0);
    chk({tag, "_awlen"}, 32'(awlen), 32'd0);
    chk({tag, "_awuser_id"}, 32'(awuser_id), 32'd0);
    chk({tag, "_awuser_ap"}, 32'(awuser_ap), 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_wstrb"}, 32'(wstrb), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_drop"}, 32'(drop), 32'd0);
  endtask

  task automatic run_job(input vec_t v);
    int  aw0, b0, d0, dr0, aw_seen, naw, nb;
    bit  fin;
    aw0 = aw_addr_q.size(); b0 = beat_q.size(); d0 = done_cnt; dr0 = drop_cnt;
    if (v.load) begin
      init_addr = v.base; init_addr_en = 1'b1;
      @(posedge clk); #1;
      init_addr_en = 1'b0;
    end
    result = make_words(32'hA000_0000);
    result_en = 1'b1;
    @(posedge clk); #1;
    result_en = 1'b0;
    chk("busy_after_strobe", 32'(busy), 32'd1);
    chk("awvalid_latency", 32'(awvalid), 32'd1);
    chk("awuser_id", 32'(awuser_id), 32'h6);
    aw_seen = 0; wready = 1'b1; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (awvalid) begin
        awready = (aw_seen >= v.aw_stall);
        aw_seen++;
      end else begin
        awready = 1'b0;
      end
      wready = v.w_toggle ? ~wready : 1'b1;
      init_addr_en = v.mid_load && (cyc == 3);
      if (v.mid_load && cyc == 3) init_addr = v.mid_addr;
      result_en = v.mid_strobe && (cyc == 8);
      result = (v.mid_strobe && cyc == 8) ? make_words(32'hB000_0000) : make_words(32'hA000_0000);
      @(posedge clk); #1;
      fin = (done_cnt != d0);
    end
    result_en = 1'b0; init_addr_en = 1'b0;
    chk("done_timeout", 32'(fin), 32'd1);
    repeat (5) begin
      awready = 1'b1; wready = 1'b1;
      @(posedge clk); #1;
    end
    naw = aw_addr_q.size() - aw0;
    nb  = beat_q.size() - b0;
    chk("aw_count", 32'(naw), 32'd2);
    chk("beat_count", 32'(nb), 32'(NW));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("drop_count", 32'(drop_cnt - dr0), 32'(v.mid_strobe));
    chk("busy_end", 32'(busy), 32'd0);
    if (naw >= 2) begin
      chk("awaddr0", 32'(aw_addr_q[aw0]), 32'(v.exp_a0));
      chk("awaddr1", 32'(aw_addr_q[aw0+1]), 32'(v.exp_a1));
      chk("awlen0", 32'(aw_len_q[aw0]), 32'(v.exp_len0));
      chk("awlen1", 32'(aw_len_q[aw0+1]), 32'(v.exp_len1));
      chk("awap0", 32'(aw_ap_q[aw0]), 32'd0);
      chk("awap1", 32'(aw_ap_q[aw0+1]), 32'd1);
    end
    for (int k = 0; k < nb && k < NW; k++) begin
      chk($sformatf("beat%0d_data", k), beat_q[b0+k], 32'hA000_0000 + 32'(k));
      chk($sformatf("beat%0d_last", k), 32'(last_q[b0+k]), (k == 15 || k == 19) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NW*32-1:0] tmp;
    int b0, ab0, cnt;
    bit fin;
    vec_t rv;

    vecs[0] = '{1'b1, 28'h100, 0, 1'b0, 1'b0, 28'h0, 1'b0, 28'h100, 28'h140, 4'd15, 4'd3};
    vecs[1] = '{1'b1, 28'h100, 5, 1'b1, 1'b0, 28'h0, 1'b0, 28'h100, 28'h140, 4'd15, 4'd3};
    vecs[2] = '{1'b1, 28'h100, 0, 1'b0, 1'b1, 28'h200, 1'b0, 28'h100, 28'h140, 4'd15, 4'd3};
    vecs[3] = '{1'b0, 28'h0, 0, 1'b0, 1'b0, 28'h0, 1'b0, 28'h200, 28'h240, 4'd15, 4'd3};
    vecs[4] = '{1'b1, 28'hFFFFFC0, 2, 1'b1, 1'b0, 28'h0, 1'b0, 28'hFFFFFC0, 28'h0000000, 4'd15, 4'd3};
    vecs[5] = '{1'b1, 28'h100, 0, 1'b0, 1'b0, 28'h0, 1'b1, 28'h100, 28'h140, 4'd15, 4'd3};

    rst = 1'b1;
    result_en = 1'b0; result = '0; init_addr = 28'd0; init_addr_en = 1'b0;
    awready = 1'b0; wready = 1'b0;
    s_result_en = 1'b0; s_result = '0; s_init_addr = 28'd0; s_init_addr_en = 1'b0;
    s_awready = 1'b1; s_wready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Small build: second burst address wraps past 2^28.
    s_init_addr = 28'hFFFFFF8; s_init_addr_en = 1'b1;
    @(posedge clk); #1;
    s_init_addr_en = 1'b0;
    tmp = make_words(32'hC000_0000);
    s_result = tmp[NS*32-1:0];
    s_result_en = 1'b1;
    @(posedge clk); #1;
    s_result_en = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      @(posedge clk); #1;
      fin = (s_done_cnt != 0);
    end
    chk("small_done", 32'(fin), 32'd1);
    chk("small_aw_count", 32'(s_aw_addr_q.size()), 32'd2);
    chk("small_beat_count", 32'(s_beat_q.size()), 32'(NS));
    if (s_aw_addr_q.size() >= 2) begin
      chk("small_awaddr0", 32'(s_aw_addr_q[0]), 32'h0FFFFFF8);
      chk("small_awaddr1", 32'(s_aw_addr_q[1]), 32'h00000008);
      chk("small_awlen0", 32'(s_aw_len_q[0]), 32'd3);
      chk("small_awlen1", 32'(s_aw_len_q[1]), 32'd3);
      chk("small_awap0", 32'(s_aw_ap_q[0]), 32'd0);
      chk("small_awap1", 32'(s_aw_ap_q[1]), 32'd1);
    end
    for (int k = 0; k < s_beat_q.size() && k < NS; k++) begin
      chk($sformatf("small_beat%0d", k), s_beat_q[k], 32'hC000_0000 + 32'(k));
      chk($sformatf("small_last%0d", k), 32'(s_last_q[k]), (k == 3 || k == 7) ? 32'd1 : 32'd0);
    end

    // Reset while streaming burst 0, then a fresh job from word 0.
    b0 = beat_q.size(); ab0 = aw_addr_q.size();
    result = make_words(32'hA000_0000);
    awready = 1'b1; wready = 1'b1;
    result_en = 1'b1;
    @(posedge clk); #1;
    result_en = 1'b0;
    cnt = 0;
    while (beat_q.size() - b0 < 3 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("three_beats_seen", 32'(beat_q.size() - b0), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midrst_stays_idle", 32'(awvalid), 32'd0);
    rv = '{1'b1, 28'h300, 0, 1'b0, 1'b0, 28'h0, 1'b0, 28'h300, 28'h340, 4'd15, 4'd3};
    run_job(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
